// File: rtl/bias_act_pkg.sv
// Shared types and Q8.8 constants for the bias + activation stage.
package bias_act_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_HSIG  = 2'd2,
    ACT_HTANH = 2'd3
  } act_e;

  localparam logic signed [15:0] Q_ONE     = 16'sh0100;
  localparam logic signed [15:0] Q_NEG_ONE = 16'shFF00;
  localparam logic signed [15:0] Q_HALF    = 16'sh0080;
  localparam logic signed [15:0] Q_ZERO    = 16'sh0000;
  localparam logic signed [15:0] Q_MAX     = 16'sh7FFF;
  localparam logic signed [15:0] Q_MIN     = 16'sh8000;

  // Controller states, kept as plain constants so older tools can read the encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Clamp a 17-bit signed sum back into the Q8.8 range instead of wrapping.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    logic signed [15:0] r;
    if (x > 17'sd32767) begin
      r = Q_MAX;
    end else if (x < -17'sd32768) begin
      r = Q_MIN;
    end else begin
      r = x[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/bias_act_if.sv
// Bundle of the control handshake, the matmul/bias read ports and the destination write port.
interface bias_act_if import bias_act_pkg::*; #(
  parameter int LEN_BITS = 4
);

  logic                start;
  act_e                act_sel;
  logic [LEN_BITS-1:0] src_sel;
  logic [15:0]         src_data;
  logic [LEN_BITS-1:0] bias_sel;
  logic [15:0]         bias_data;
  logic                dst_write;
  logic [LEN_BITS-1:0] dst_sel;
  logic [15:0]         dst_data;
  logic                ready;
  logic                busy;
  logic                done;

  modport master (
    output start, act_sel, src_data, bias_data,
    input  src_sel, bias_sel, dst_write, dst_sel, dst_data, ready, busy, done
  );

  modport slave (
    input  start, act_sel, src_data, bias_data,
    output src_sel, bias_sel, dst_write, dst_sel, dst_data, ready, busy, done
  );

endinterface

// File: rtl/bias_act_act_unit.sv
// Combinational activation function over one signed Q8.8 value.
module act_unit import bias_act_pkg::*; (
  input  act_e               act_i,
  input  logic signed [15:0] s_i,
  output logic signed [15:0] y_o
);

  logic signed [16:0] sWide;
  logic signed [16:0] hsigSum;

  assign sWide   = {s_i[15], s_i};
  assign hsigSum = (sWide >>> 2) + 17'sd128;

  // Select the activation; hard-sigmoid works in 17 bits so the +HALF offset cannot wrap.
  always_comb begin
    y_o = s_i;
    case (act_i)
      ACT_NONE: begin
        y_o = s_i;
      end
      ACT_RELU: begin
        y_o = s_i[15] ? Q_ZERO : s_i;
      end
      ACT_HSIG: begin
        if (hsigSum < 17'sd0) begin
          y_o = Q_ZERO;
        end else if (hsigSum > 17'sd256) begin
          y_o = Q_ONE;
        end else begin
          y_o = hsigSum[15:0];
        end
      end
      ACT_HTANH: begin
        if (s_i > Q_ONE) begin
          y_o = Q_ONE;
        end else if (s_i < Q_NEG_ONE) begin
          y_o = Q_NEG_ONE;
        end else begin
          y_o = s_i;
        end
      end
      default: begin
        y_o = s_i;
      end
    endcase
  end

endmodule

// File: rtl/bias_act.sv
// Streams the matmul result vector, adds bias, applies the latched activation and writes out.
module bias_act import bias_act_pkg::*; #(
  parameter int LEN_BITS = 4
) (
  input logic       clk,
  input logic       rst,
  bias_act_if.slave bus
);

  localparam logic [LEN_BITS-1:0] LAST_IDX = '1;

  logic [1:0]          state_q, state_d;
  logic [LEN_BITS-1:0] idx_q, idx_d;
  act_e                act_q, act_d;

  logic                vA_q;
  logic [LEN_BITS-1:0] idxA_q;

  logic                v1_q;
  logic [LEN_BITS-1:0] idx1_q;
  logic signed [15:0]  sum1_q;

  logic                dstWrite_q;
  logic [LEN_BITS-1:0] dstSel_q;
  logic [15:0]         dstData_q;
  logic                done_q;

  logic signed [16:0]  sumWide;
  logic signed [15:0]  actY;

  assign sumWide = {bus.src_data[15], bus.src_data} + {bus.bias_data[15], bus.bias_data};

  act_unit u_act (
    .act_i (act_q),
    .s_i   (sum1_q),
    .y_o   (actY)
  );

  // Next-state logic: accept start only when idle, walk the index once, then let the pipe drain.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          act_d   = bus.act_sel;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (done_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Controller registers: state, issue index and the activation latched at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      act_q   <= ACT_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
    end
  end

  // Track which index the source/bias memories are presenting, one cycle behind the select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vA_q   <= 1'b0;
      idxA_q <= '0;
    end else begin
      vA_q   <= (state_q == ST_RUN);
      idxA_q <= idx_q;
    end
  end

  // Saturating bias add on the data returned by the memories.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      sum1_q <= Q_ZERO;
    end else begin
      v1_q   <= vA_q;
      idx1_q <= idxA_q;
      if (vA_q) begin
        sum1_q <= sat16(sumWide);
      end
    end
  end

  // Registered destination write port; done marks the write of the final index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstWrite_q <= 1'b0;
      dstSel_q   <= '0;
      dstData_q  <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      dstWrite_q <= v1_q;
      done_q     <= v1_q && (idx1_q == LAST_IDX);
      if (v1_q) begin
        dstSel_q  <= idx1_q;
        dstData_q <= actY;
      end
    end
  end

  assign bus.src_sel   = idx_q;
  assign bus.bias_sel  = idx_q;
  assign bus.dst_write = dstWrite_q;
  assign bus.dst_sel   = dstSel_q;
  assign bus.dst_data  = dstData_q;
  assign bus.done      = done_q;
  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bias_act.sv
// Self-checking bench for bias_act with registered-read source/bias memory models.
module tb_bias_act;
  import bias_act_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  bias_act_if #(.LEN_BITS(4)) bus ();

  bias_act #(.LEN_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  act_e               uaAct;
  logic signed [15:0] uaS;
  logic signed [15:0] uaY;

  act_unit ua (
    .act_i (uaAct),
    .s_i   (uaS),
    .y_o   (uaY)
  );

  logic [15:0] srcMem  [16];
  logic [15:0] biasMem [16];
  logic [15:0] expQ    [16];

  logic [3:0]  wIdx [$];
  logic [15:0] wData[$];
  int          wCyc [$];
  int          nDone, doneCyc, readyCyc, selMismatch;
  logic        rstWrite, rstReady;

  always #5 clk = ~clk;

  // Matmul accumulator and bias tensor: data appears one cycle after the select.
  always @(posedge clk) begin
    bus.src_data  <= srcMem[bus.src_sel];
    bus.bias_data <= biasMem[bus.bias_sel];
  end

  function automatic int toInt(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clampI(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int floorDiv4(input int x);
    int q;
    q = x / 4;
    if (x < 0 && (x % 4) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] actRef(input int act, input int s);
    int y;
    case (act)
      1:       y = (s < 0) ? 0 : s;
      2:       y = clampI(floorDiv4(s) + 128, 0, 256);
      3:       y = clampI(s, -256, 256);
      default: y = s;
    endcase
    return 16'(y);
  endfunction

  function automatic logic [15:0] pickVal();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h7FFF;
      1:       v = 16'h8000;
      2:       v = 16'(($urandom_range(0, 1023)) - 512);
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic buildExp(input int act);
    for (int i = 0; i < 16; i++) begin
      expQ[i] = actRef(act, clampI(toInt(srcMem[i]) + toInt(biasMem[i]), -32768, 32767));
    end
  endtask

  task automatic randomMem();
    for (int i = 0; i < 16; i++) begin
      srcMem[i]  = pickVal();
      biasMem[i] = pickVal();
    end
  endtask

  // Start a run and record every observable event for 30 cycles after the accepting edge.
  task automatic applyStimulus(input int act, input int restartCyc, input bit toggleAct,
                               input int resetCyc);
    wIdx.delete(); wData.delete(); wCyc.delete();
    nDone = 0; doneCyc = -1; readyCyc = -1; selMismatch = 0;
    rstWrite = 1'b0; rstReady = 1'b0;
    @(negedge clk);
    bus.act_sel = act_e'(act);
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (rst) rst = 1'b0;
      if (bus.dst_write) begin
        wIdx.push_back(bus.dst_sel);
        wData.push_back(bus.dst_data);
        wCyc.push_back(c);
      end
      if (bus.done) begin
        nDone++;
        doneCyc = c;
      end
      if (bus.src_sel !== bus.bias_sel) selMismatch++;
      if (readyCyc < 0 && bus.ready === 1'b1) readyCyc = c;
      bus.start = (c == restartCyc);
      if (toggleAct) bus.act_sel = act_e'($urandom_range(0, 3));
      if (c == resetCyc) begin
        rst = 1'b1;
        #1;
        rstWrite = bus.dst_write;
        rstReady = bus.ready;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.act_sel = ACT_NONE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b want=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.dst_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_write got=%b want=0", bus.dst_write); end
    checks++; if (bus.src_sel !== 4'd0 || bus.bias_sel !== 4'd0 || bus.dst_sel !== 4'd0) begin
      failures++; $display("[TB] FAIL reset_sels got=%0d/%0d/%0d want=0/0/0", bus.src_sel, bus.bias_sel, bus.dst_sel);
    end
    checks++; if (bus.dst_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data got=%h want=0000", bus.dst_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_ready got=%b want=1", bus.ready); end
  endtask

  task automatic test_none_directed();
    for (int i = 0; i < 16; i++) begin
      srcMem[i]  = 16'(i << 8);
      biasMem[i] = 16'h0080;
    end
    applyStimulus(0, -1, 1'b0, -1);
    checks++; if (wIdx.size() != 16) begin failures++; $display("[TB] FAIL none_count got=%0d want=16", wIdx.size()); end
    for (int i = 0; i < 16 && i < wIdx.size(); i++) begin
      checks++;
      if (wIdx[i] !== 4'(i) || wData[i] !== 16'((i << 8) + 128) || wCyc[i] != i + 3) begin
        failures++;
        $display("[TB] FAIL none_entry%0d got=idx%0d/%h@%0d want=idx%0d/%h@%0d", i, wIdx[i], wData[i], wCyc[i], i, 16'((i << 8) + 128), i + 3);
      end
    end
    checks++; if (nDone != 1 || doneCyc != 18) begin failures++; $display("[TB] FAIL none_done got=%0dx@%0d want=1x@18", nDone, doneCyc); end
    checks++; if (readyCyc != 19) begin failures++; $display("[TB] FAIL none_ready got=%0d want=19", readyCyc); end
    checks++; if (selMismatch != 0) begin failures++; $display("[TB] FAIL none_biassel got=%0d want=0", selMismatch); end
    checks++; if (bus.src_sel !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL none_idle got=sel%0d/busy%b want=sel0/busy0", bus.src_sel, bus.busy); end
  endtask

  task automatic test_relu();
    randomMem();
    for (int i = 0; i < 16; i++) biasMem[i] = 16'h0000;
    srcMem[0] = 16'hFF00;
    srcMem[1] = 16'h0100;
    buildExp(1);
    applyStimulus(1, -1, 1'b0, -1);
    checks++; if (wIdx.size() != 16) begin failures++; $display("[TB] FAIL relu_count got=%0d want=16", wIdx.size()); end
    if (wData.size() >= 2) begin
      checks++; if (wData[0] !== 16'h0000) begin failures++; $display("[TB] FAIL relu_neg got=%h want=0000", wData[0]); end
      checks++; if (wData[1] !== 16'h0100) begin failures++; $display("[TB] FAIL relu_pos got=%h want=0100", wData[1]); end
    end
    for (int i = 0; i < wData.size(); i++) begin
      checks++; if (wData[i] !== expQ[i]) begin failures++; $display("[TB] FAIL relu_entry%0d got=%h want=%h", i, wData[i], expQ[i]); end
    end
  endtask

  task automatic test_hsig();
    logic [15:0] want[4];
    randomMem();
    srcMem[0] = 16'h0000; srcMem[1] = 16'h0400; srcMem[2] = 16'hFC00; srcMem[3] = 16'h0100;
    for (int i = 0; i < 4; i++) biasMem[i] = 16'h0000;
    want[0] = 16'h0080; want[1] = 16'h0100; want[2] = 16'h0000; want[3] = 16'h00C0;
    buildExp(2);
    applyStimulus(2, -1, 1'b0, -1);
    checks++; if (wIdx.size() != 16) begin failures++; $display("[TB] FAIL hsig_count got=%0d want=16", wIdx.size()); end
    for (int i = 0; i < 4 && i < wData.size(); i++) begin
      checks++; if (wData[i] !== want[i]) begin failures++; $display("[TB] FAIL hsig_point%0d got=%h want=%h", i, wData[i], want[i]); end
    end
    for (int i = 0; i < wData.size(); i++) begin
      checks++; if (wData[i] !== expQ[i]) begin failures++; $display("[TB] FAIL hsig_entry%0d got=%h want=%h", i, wData[i], expQ[i]); end
    end
  endtask

  task automatic test_htanh();
    randomMem();
    srcMem[0] = 16'h7F00; biasMem[0] = 16'h7F00;
    srcMem[1] = 16'h8000; biasMem[1] = 16'hFF00;
    buildExp(3);
    applyStimulus(3, -1, 1'b0, -1);
    checks++; if (wIdx.size() != 16) begin failures++; $display("[TB] FAIL htanh_count got=%0d want=16", wIdx.size()); end
    if (wData.size() >= 2) begin
      checks++; if (wData[0] !== 16'h0100) begin failures++; $display("[TB] FAIL htanh_satpos got=%h want=0100", wData[0]); end
      checks++; if (wData[1] !== 16'hFF00) begin failures++; $display("[TB] FAIL htanh_satneg got=%h want=ff00", wData[1]); end
    end
    for (int i = 0; i < wData.size(); i++) begin
      checks++; if (wData[i] !== expQ[i]) begin failures++; $display("[TB] FAIL htanh_entry%0d got=%h want=%h", i, wData[i], expQ[i]); end
    end
  endtask

  task automatic test_random();
    int act;
    for (int r = 0; r < 8; r++) begin
      act = (r < 4) ? r : int'($urandom_range(0, 3));
      randomMem();
      buildExp(act);
      applyStimulus(act, -1, 1'b0, -1);
      checks++; if (wIdx.size() != 16 || nDone != 1) begin failures++; $display("[TB] FAIL rand%0d_count got=%0dw/%0dd want=16w/1d", r, wIdx.size(), nDone); end
      for (int i = 0; i < wData.size(); i++) begin
        checks++;
        if (wIdx[i] !== 4'(i) || wData[i] !== expQ[i]) begin
          failures++; $display("[TB] FAIL rand%0d_entry%0d got=idx%0d/%h want=idx%0d/%h", r, i, wIdx[i], wData[i], i, expQ[i]);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    randomMem();
    buildExp(2);
    applyStimulus(2, 5, 1'b1, -1);
    checks++; if (wIdx.size() != 16) begin failures++; $display("[TB] FAIL restart_count got=%0d want=16", wIdx.size()); end
    checks++; if (nDone != 1) begin failures++; $display("[TB] FAIL restart_done got=%0d want=1", nDone); end
    checks++; if (readyCyc != 19) begin failures++; $display("[TB] FAIL restart_ready got=%0d want=19", readyCyc); end
    for (int i = 0; i < wData.size(); i++) begin
      checks++;
      if (wIdx[i] !== 4'(i) || wData[i] !== expQ[i] || wCyc[i] != i + 3) begin
        failures++; $display("[TB] FAIL restart_entry%0d got=idx%0d/%h@%0d want=idx%0d/%h@%0d", i, wIdx[i], wData[i], wCyc[i], i, expQ[i], i + 3);
      end
    end
  endtask

  task automatic test_reset_midrun();
    randomMem();
    buildExp(0);
    applyStimulus(0, -1, 1'b0, 8);
    checks++; if (rstWrite !== 1'b0) begin failures++; $display("[TB] FAIL midrst_write got=%b want=0", rstWrite); end
    checks++; if (rstReady !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%b want=1", rstReady); end
    checks++; if (wIdx.size() != 6) begin failures++; $display("[TB] FAIL midrst_count got=%0d want=6", wIdx.size()); end
    checks++; if (nDone != 0) begin failures++; $display("[TB] FAIL midrst_done got=%0d want=0", nDone); end
    checks++; if (readyCyc != 9) begin failures++; $display("[TB] FAIL midrst_readyafter got=%0d want=9", readyCyc); end
    for (int i = 0; i < wData.size() && i < 6; i++) begin
      checks++; if (wIdx[i] !== 4'(i) || wData[i] !== expQ[i]) begin failures++; $display("[TB] FAIL midrst_entry%0d got=idx%0d/%h want=idx%0d/%h", i, wIdx[i], wData[i], i, expQ[i]); end
    end
  endtask

  task automatic test_back_to_back();
    randomMem();
    buildExp(1);
    applyStimulus(1, -1, 1'b0, -1);
    checks++; if (wIdx.size() != 16 || nDone != 1 || doneCyc != 18) begin
      failures++; $display("[TB] FAIL b2b_shape got=%0dw/%0dd@%0d want=16w/1d@18", wIdx.size(), nDone, doneCyc);
    end
    for (int i = 0; i < wData.size(); i++) begin
      checks++; if (wIdx[i] !== 4'(i) || wData[i] !== expQ[i]) begin failures++; $display("[TB] FAIL b2b_entry%0d got=idx%0d/%h want=idx%0d/%h", i, wIdx[i], wData[i], i, expQ[i]); end
    end
  endtask

  task automatic test_act_unit();
    logic [15:0] want;
    for (int k = 0; k < 200; k++) begin
      uaAct = act_e'(k % 4);
      uaS   = $signed(pickVal());
      #1;
      want = actRef(k % 4, toInt(uaS));
      checks++; if (uaY !== want) begin failures++; $display("[TB] FAIL actunit act%0d s=%h got=%h want=%h", k % 4, uaS, uaY, want); end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.act_sel = ACT_NONE;
    for (int i = 0; i < 16; i++) begin
      srcMem[i]  = 16'h0000;
      biasMem[i] = 16'h0000;
    end
    uaAct = ACT_NONE;
    uaS   = 16'sh0000;
    test_reset();
    test_act_unit();
    test_none_directed();
    test_relu();
    test_hsig();
    test_htanh();
    test_random();
    test_restart_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
